// File: rtl/pipe_cla_adder.sv
// Two-stage pipelined 32-bit carry-lookahead adder/subtractor with valid/ready flow control.
// S1 registers bitwise and per-group propagate/generate; S2 resolves carries and registers the result.
module pipe_cla_adder (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [1:0]  op,
   input  logic        carry_in,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] sum,
   output logic        cout,
   output logic        ovf,
   output logic        zero
);

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_ADC = 2'b10;
   localparam logic [1:0] OP_SBC = 2'b11;

   function automatic logic group_gen(input logic [3:0] p, input logic [3:0] g);
      return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
   endfunction

   // Flattened sum-of-products per group carry, so no carry ripples group to group.
   function automatic logic [8:0] group_carries(input logic [7:0] px, input logic [7:0] gx,
                                                input logic c0);
      logic [8:0] c;
      logic       prod;
      logic       acc;
      c    = 9'd0;
      c[0] = c0;
      for (int k = 0; k < 8; k++) begin
         prod = c0;
         for (int m = 0; m <= k; m++) prod = prod & px[m];
         acc = prod;
         for (int j = 0; j <= k; j++) begin
            prod = gx[j];
            for (int m = j + 1; m <= k; m++) prod = prod & px[m];
            acc = acc | prod;
         end
         c[k+1] = acc;
      end
      return c;
   endfunction

   function automatic logic [31:0] group_sums(input logic [31:0] p, input logic [31:0] g,
                                              input logic [8:0] gc);
      logic [31:0] s;
      logic        c;
      s = 32'd0;
      c = 1'b0;
      for (int k = 0; k < 8; k++) begin
         c = gc[k];
         for (int i = 0; i < 4; i++) begin
            s[4*k+i] = p[4*k+i] ^ c;
            c        = g[4*k+i] | (p[4*k+i] & c);
         end
      end
      return s;
   endfunction

   logic [31:0] w_bx;
   logic        w_c0;
   logic [31:0] w_p;
   logic [31:0] w_g;
   logic [7:0]  w_px;
   logic [7:0]  w_gx;
   logic        w_adv1;
   logic        w_adv2;
   logic [8:0]  w_gc;
   logic [31:0] w_sum;
   logic        w_ovf;

   logic [31:0] r_p;
   logic [31:0] r_g;
   logic [7:0]  r_px;
   logic [7:0]  r_gx;
   logic        r_c0;
   logic        r_a31;
   logic        r_bx31;
   logic        r_s1_valid;
   logic        r_s2_valid;
   logic [31:0] r_sum;
   logic        r_cout;
   logic        r_ovf;
   logic        r_zero;

   always_comb begin
      w_bx = b;
      w_c0 = 1'b0;
      case (op)
         OP_ADD:  begin w_bx = b;  w_c0 = 1'b0;     end
         OP_SUB:  begin w_bx = ~b; w_c0 = 1'b1;     end
         OP_ADC:  begin w_bx = b;  w_c0 = carry_in; end
         OP_SBC:  begin w_bx = ~b; w_c0 = carry_in; end
         default: begin w_bx = b;  w_c0 = 1'b0;     end
      endcase
   end

   assign w_p = a ^ w_bx;
   assign w_g = a & w_bx;

   always_comb begin
      w_px = 8'd0;
      w_gx = 8'd0;
      for (int k = 0; k < 8; k++) begin
         w_px[k] = &w_p[4*k +: 4];
         w_gx[k] = group_gen(w_p[4*k +: 4], w_g[4*k +: 4]);
      end
   end

   assign w_adv2   = !r_s2_valid || out_ready;
   assign w_adv1   = !r_s1_valid || w_adv2;
   assign in_ready = w_adv1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
      end else if (w_adv1) begin
         r_s1_valid <= in_valid;
      end
   end

   // S1 payload carries no reset; only its valid bit qualifies it.
   always_ff @(posedge clk) begin
      if (w_adv1 && in_valid) begin
         r_p    <= w_p;
         r_g    <= w_g;
         r_px   <= w_px;
         r_gx   <= w_gx;
         r_c0   <= w_c0;
         r_a31  <= a[31];
         r_bx31 <= w_bx[31];
      end
   end

   assign w_gc  = group_carries(r_px, r_gx, r_c0);
   assign w_sum = group_sums(r_p, r_g, w_gc);
   assign w_ovf = (r_a31 == r_bx31) && (w_sum[31] != r_a31);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s2_valid <= 1'b0;
         r_sum      <= 32'd0;
         r_cout     <= 1'b0;
         r_ovf      <= 1'b0;
         r_zero     <= 1'b0;
      end else if (w_adv2) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_sum  <= w_sum;
            r_cout <= w_gc[8];
            r_ovf  <= w_ovf;
            r_zero <= (w_sum == 32'd0);
         end
      end
   end

   assign out_valid = r_s2_valid;
   assign sum       = r_sum;
   assign cout      = r_cout;
   assign ovf       = r_ovf;
   assign zero      = r_zero;

endmodule
